sad_accum_4b: RTL and testbench
===============================

Name: sad_accum_4b

Overview:
Sequential sum-of-absolute-differences (SAD) stage built on the 4b absolute-difference datapath. Consumes a stream of 4b operand pairs over a val/rdy interface. Per pair it computes |in0 - in1| using an internal greater-than compare and subtract, then accumulates N_PAIRS results into one frame sum. Emits the frame SAD to a downstream consumer over a val/rdy interface.

Parameters:
N_PAIRS, 4, number of operand pairs per frame; legal range is 1 or more.
SUM_NBITS, 8, width of the accumulated sum; legal range is 4 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_val  input  1  operand pair valid
in_rdy  output  1  stage can accept a pair
in0  input  4  operand A, unsigned
in1  input  4  operand B, unsigned
out_val  output  1  frame result valid
out_rdy  input  1  downstream can accept the result
sad  output  SUM_NBITS  accumulated sum of |in0-in1| over the frame
ovf  output  1  sum saturated during this frame

Behaviour:
- FSM has two states.
  - ACC: in_rdy=1, out_val=0.
  - DONE: in_rdy=0, out_val=1.
  - in_rdy and out_val are decoded from the state only. No combinational path from in_val or out_rdy to any output.
- Reset (rst=1 on a rising edge):
  - Next state is ACC; count=0, sum=0, ovf=0.
  - While rst is high, in_rdy=0 and out_val=0.
  - Reset mid-frame discards all partial state; no result is emitted for that frame.
- In ACC, a transfer occurs when in_val && in_rdy. On each transfer:
  - gt = (in0 > in1), unsigned.
  - diff = gt ? in0-in1 : in1-in0. diff is 4b; (in0==in1) gives diff=0.
  - sum_next = sum + zero-extended diff, saturating at 2^SUM_NBITS-1.
  - If the unsaturated add exceeds the maximum, ovf becomes 1. ovf is sticky for the rest of the frame.
  - count increments.
- Frame end: the transfer at count == N_PAIRS-1 moves the FSM to DONE on the next edge, with the final sum included.
  - Latency: out_val rises on the cycle after the Nth transfer.
- No state change occurs in ACC when in_val=0. count and sum hold, and gaps are allowed anywhere in a frame.
- DONE:
  - sad and ovf hold stable while out_val=1 and out_rdy=0. Backpressure is unlimited.
  - When out_rdy=1, the result transfers. Next edge: state ACC, count=0, sum=0, ovf=0.
  - in_rdy is 0 in DONE, so there is one mandatory bubble between frames and no bypass.
- sad is driven from the sum register in every state. Its value is only meaningful while out_val=1.
- Count register width is max(1, $clog2(N_PAIRS)). With N_PAIRS=1, every transfer ends a frame.
- Inputs in0 and in1 are sampled only on a transfer cycle. X on in0/in1 when in_val=0 must not corrupt state.

Test Plan:
1. Basic frame (N_PAIRS=4, SUM_NBITS=8). Send (3,7), (9,2), (5,5), (15,0) back-to-back with out_rdy=1.
   - Required: diffs 4, 7, 0, 15; out_val=1 exactly one cycle after the 4th transfer; sad=26; ovf=0.
   - Required: in_rdy=0 for that one cycle, then 1.
2. Backpressure. Repeat scenario 1 with out_rdy=0 for 5 cycles after out_val rises.
   - Required: out_val=1, sad=26 and in_rdy=0 held for all 5 cycles. Transfer on the cycle out_rdy=1, then in_rdy=1 next cycle.
3. Input gaps. Send the same 4 pairs with in_val=0 for 2 cycles between each pair, and X on in0/in1 during the gaps.
   - Required: sad=26, same as scenario 1; out_val only after the 4th real transfer.
4. Saturation (SUM_NBITS=4, N_PAIRS=4). Send (15,0), (0,15), (1,0), (0,0).
   - Required: sad=15 and ovf=1 at out_val. The following frame of (1,2)x4 gives sad=4, ovf=0.
5. Reset mid-frame. Transfer (10,0), (0,10), then assert rst for 1 cycle, then send (1,0)x4.
   - Required: no out_val before the new frame completes; sad=4.
6. N_PAIRS=1. Send (0,15), then (8,8).
   - Required: two results, sad=15 and then 0, each one cycle after its transfer, with one bubble between them.

Source files
------------

// File: rtl/sad_accum_4b.sv
// Streaming sum-of-absolute-differences stage: accumulates N_PAIRS 4b |a-b| values per frame
// and hands the saturating frame sum downstream over a val/rdy handshake.
module sad_accum_4b #(
  parameter int unsigned N_PAIRS   = 4,
  parameter int unsigned SUM_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [3:0]           in0,
  input  logic [3:0]           in1,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [SUM_NBITS-1:0] sad,
  output logic                 ovf
);

  localparam int unsigned CntW  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
  localparam int unsigned SumW1 = SUM_NBITS + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_PAIRS - 1);

  typedef enum logic {StAcc, StDone} state_e;

  state_e               r_state, w_state_d;
  logic [CntW-1:0]      r_cnt, w_cnt_d;
  logic [SUM_NBITS-1:0] r_sum, w_sum_d;
  logic                 r_ovf, w_ovf_d;

  logic                 w_gt;
  logic [3:0]           w_diff;
  logic [SUM_NBITS:0]   w_add;
  logic                 w_xfer;

  always_comb begin
    w_gt   = (in0 > in1);
    w_diff = w_gt ? (in0 - in1) : (in1 - in0);
    // Extra top bit is the carry that signals the add ran past the saturation ceiling.
    w_add  = {1'b0, r_sum} + SumW1'(w_diff);
    w_xfer = in_val && (r_state == StAcc);
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sum_d   = r_sum;
    w_ovf_d   = r_ovf;
    unique case (r_state)
      StAcc: begin
        if (w_xfer) begin
          w_cnt_d = r_cnt + CntW'(1);
          if (w_add[SUM_NBITS]) begin
            w_sum_d = '1;
            w_ovf_d = 1'b1;
          end else begin
            w_sum_d = w_add[SUM_NBITS-1:0];
          end
          if (r_cnt == CntLast) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_rdy) begin
          w_state_d = StAcc;
          w_cnt_d   = '0;
          w_sum_d   = '0;
          w_ovf_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StAcc;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_sum   <= w_sum_d;
      r_ovf   <= w_ovf_d;
    end
  end

  // Handshake outputs are masked while reset is held so nothing is offered or accepted.
  assign in_rdy  = (r_state == StAcc) && !rst;
  assign out_val = (r_state == StDone) && !rst;
  assign sad     = r_sum;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_sad_accum_4b.sv
// Bench for sad_accum_4b: three configurations share one stimulus stream and are checked every
// cycle against a frame-level reference model, plus directed scenarios with literal results.
module tb_sad_accum_4b;

  logic       clk;
  logic       rst;
  logic       in_val;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       out_rdy;
  logic [2:0] rdy;
  logic [2:0] val;
  logic [2:0] ov;
  logic [7:0] sad_a;
  logic [3:0] sad_s;
  logic [7:0] sad_1;

  int total = 0;
  int bad   = 0;

  // Configurations: 0 = (4 pairs, 8b), 1 = (4 pairs, 4b saturating), 2 = (1 pair, 8b)
  localparam int NP [3] = '{4, 4, 1};
  localparam int NB [3] = '{8, 4, 8};

  sad_accum_4b #(.N_PAIRS(4), .SUM_NBITS(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy[0]), .in0(in0), .in1(in1),
    .out_val(val[0]), .out_rdy(out_rdy), .sad(sad_a), .ovf(ov[0])
  );
  sad_accum_4b #(.N_PAIRS(4), .SUM_NBITS(4)) u_dut_s (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy[1]), .in0(in0), .in1(in1),
    .out_val(val[1]), .out_rdy(out_rdy), .sad(sad_s), .ovf(ov[1])
  );
  sad_accum_4b #(.N_PAIRS(1), .SUM_NBITS(8)) u_dut_1 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(rdy[2]), .in0(in0), .in1(in1),
    .out_val(val[2]), .out_rdy(out_rdy), .sad(sad_1), .ovf(ov[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: transfers taken so far this frame, running clipped sum, sticky overflow,
  // and whether the frame is complete and waiting on the consumer.
  int m_cnt  [3] = '{0, 0, 0};
  int m_sum  [3] = '{0, 0, 0};
  bit m_ovf  [3] = '{0, 0, 0};
  bit m_done [3] = '{0, 0, 0};

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int maxv(input int nb);
    return (1 << nb) - 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k]  <= 0;
        m_sum[k]  <= 0;
        m_ovf[k]  <= 1'b0;
        m_done[k] <= 1'b0;
      end else if (!m_done[k]) begin
        if (in_val) begin
          if (m_sum[k] + absd(int'(in0), int'(in1)) > maxv(NB[k])) begin
            m_sum[k] <= maxv(NB[k]);
            m_ovf[k] <= 1'b1;
          end else begin
            m_sum[k] <= m_sum[k] + absd(int'(in0), int'(in1));
          end
          m_cnt[k] <= m_cnt[k] + 1;
          if (m_cnt[k] + 1 == NP[k]) m_done[k] <= 1'b1;
        end
      end else if (out_rdy) begin
        m_cnt[k]  <= 0;
        m_sum[k]  <= 0;
        m_ovf[k]  <= 1'b0;
        m_done[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sad_of(input int k);
    case (k)
      0:       return int'(sad_a);
      1:       return int'(sad_s);
      default: return int'(sad_1);
    endcase
  endfunction

  // Per-cycle comparison, sampled after outputs settle and well before inputs change.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d in_rdy", k), int'(rdy[k]), int'(!rst && !m_done[k]));
      chk($sformatf("dut%0d out_val", k), int'(val[k]), int'(!rst && m_done[k]));
      if (!rst && m_done[k]) begin
        chk($sformatf("dut%0d sad", k), sad_of(k), m_sum[k]);
        chk($sformatf("dut%0d ovf", k), int'(ov[k]), int'(m_ovf[k]));
      end
    end
  end

  // Called at a negedge; waits for the selected instance to be ready, presents one pair for a
  // single edge, and returns at the negedge after the transfer with garbage on the operands.
  task automatic xfer(input logic [3:0] a, input logic [3:0] b, input int sel);
    int n;
    n = 0;
    while (!rdy[sel] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      total++;
      bad++;
      $display("FAIL xfer timeout: dut%0d in_rdy got 0 expected 1", sel);
    end
    in_val = 1'b1;
    in0    = a;
    in1    = b;
    @(negedge clk);
    in_val = 1'b0;
    in0    = 4'($urandom);
    in1    = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    in_val  = 1'b0;
    in0     = 4'd0;
    in1     = 4'd0;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_rdy", int'(rdy[0]), 0);
    chk("reset out_val", int'(val[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset in_rdy", int'(rdy[0]), 1);
    chk("post-reset sad", int'(sad_a), 0);
    chk("post-reset ovf", int'(ov[0]), 0);

    // Basic frame: running sums 4, 11, 11, 26.
    xfer(4'd3, 4'd7, 0);  #1 chk("s1 sum1", int'(sad_a), 4);
    xfer(4'd9, 4'd2, 0);  #1 chk("s1 sum2", int'(sad_a), 11);
    xfer(4'd5, 4'd5, 0);  #1 chk("s1 sum3", int'(sad_a), 11);
    xfer(4'd15, 4'd0, 0); #1;
    chk("s1 out_val", int'(val[0]), 1);
    chk("s1 sad", int'(sad_a), 26);
    chk("s1 ovf", int'(ov[0]), 0);
    chk("s1 bubble in_rdy", int'(rdy[0]), 0);
    @(negedge clk); #1;
    chk("s1 in_rdy after", int'(rdy[0]), 1);
    chk("s1 out_val after", int'(val[0]), 0);

    // Backpressure for five cycles.
    out_rdy = 1'b0;
    xfer(4'd3, 4'd7, 0);
    xfer(4'd9, 4'd2, 0);
    xfer(4'd5, 4'd5, 0);
    xfer(4'd15, 4'd0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s2 held out_val", int'(val[0]), 1);
      chk("s2 held sad", int'(sad_a), 26);
      chk("s2 held in_rdy", int'(rdy[0]), 0);
      if (i < 4) @(negedge clk);
    end
    out_rdy = 1'b1;
    @(negedge clk); #1;
    chk("s2 in_rdy after", int'(rdy[0]), 1);

    // Gaps of two idle cycles with junk operands between pairs.
    xfer(4'd3, 4'd7, 0);  repeat (2) @(negedge clk);
    xfer(4'd9, 4'd2, 0);  repeat (2) @(negedge clk);
    xfer(4'd5, 4'd5, 0);  repeat (2) @(negedge clk);
    #1 chk("s3 no early out_val", int'(val[0]), 0);
    xfer(4'd15, 4'd0, 0); #1;
    chk("s3 out_val", int'(val[0]), 1);
    chk("s3 sad", int'(sad_a), 26);

    // Saturation in the 4b-sum instance.
    @(negedge clk);
    do_reset();
    xfer(4'd15, 4'd0, 1);
    xfer(4'd0, 4'd15, 1);
    xfer(4'd1, 4'd0, 1);
    xfer(4'd0, 4'd0, 1); #1;
    chk("s4 out_val", int'(val[1]), 1);
    chk("s4 sad", int'(sad_s), 15);
    chk("s4 ovf", int'(ov[1]), 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) xfer(4'd1, 4'd2, 1);
    #1;
    chk("s4b sad", int'(sad_s), 4);
    chk("s4b ovf", int'(ov[1]), 0);

    // Reset mid-frame discards the partial sum.
    @(negedge clk);
    do_reset();
    xfer(4'd10, 4'd0, 0);
    xfer(4'd0, 4'd10, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1 chk("s5 no out_val", int'(val[0]), 0);
      xfer(4'd1, 4'd0, 0);
    end
    #1;
    chk("s5 out_val", int'(val[0]), 1);
    chk("s5 sad", int'(sad_a), 4);

    // Single-pair frames.
    @(negedge clk);
    do_reset();
    xfer(4'd0, 4'd15, 2); #1;
    chk("s6 out_val 1", int'(val[2]), 1);
    chk("s6 sad 1", int'(sad_1), 15);
    chk("s6 bubble", int'(rdy[2]), 0);
    @(negedge clk);
    xfer(4'd8, 4'd8, 2); #1;
    chk("s6 out_val 2", int'(val[2]), 1);
    chk("s6 sad 2", int'(sad_1), 0);

    // Random traffic, occasional resets and backpressure.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 99) == 0);
      in_val  = ($urandom_range(0, 2) != 0);
      in0     = 4'($urandom);
      in1     = 4'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst    = 1'b0;
    in_val = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
